// File: rtl/serial_add_seq.sv
// Bit-serial adder sequencer: one full-adder cell stepped LSB-first over WIDTH cycles.
// Optional subtract mode is enabled by defining SERIAL_SUB_EN.
module serial_add_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic            carry;
    logic            cout_r;
    logic [CW-1:0]   cnt;
    logic            sub_eff;
    logic            fa_s;
    logic            fa_c;

`ifdef SERIAL_SUB_EN
    assign sub_eff = sub;
`else
    logic _unused;
    assign sub_eff = 1'b0;
    assign _unused = sub;
`endif

    assign fa_s = a_sh[0] ^ b_sh[0] ^ carry;
    assign fa_c = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (ena) begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = RUN;
            RUN:     if (cnt == LAST) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Subtraction is A + ~B + 1, so the carry flop starts at 1 and B is inverted on load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res    <= '0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
            cnt    <= '0;
        end else if (ena) begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= op_a;
                        b_sh  <= sub_eff ? ~op_b : op_b;
                        carry <= sub_eff;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    res   <= {fa_s, res[WIDTH-1:1]};
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= fa_c;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) cout_r <= fa_c;
                end
                default: ;
            endcase
        end
    end

    assign sum  = res;
    assign cout = cout_r;

endmodule
